my_axi4_lite_mst: RTL and testbench

Command-driven AXI4-Lite master that converts one single-beat read or write request into a complete AXI4-Lite transaction and returns the response on a valid/ready response port. It sits between local control logic (or a test sequencer) and AXI4-Lite register slaves such as our 4-register slave template. It issues one transaction at a time, with no outstanding transactions. AW and W are always presented together, which is what our slaves require.

---
 rtl/my_axi4_lite_mst_if.sv | 42 ++++
 rtl/my_axi4_lite_mst.sv | 236 +++++++++++++++++++++++
 tb/tb_my_axi4_lite_mst.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/my_axi4_lite_mst_if.sv
// AXI4-Lite bus bundle shared by the command-driven master and its slaves.
// mst_port is the master view; slv_port is the mirrored slave view.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport mst_port (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slv_port (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/my_axi4_lite_mst.sv
// Command-driven AXI4-Lite master: one single-beat read or write per command,
// no outstanding transactions, AW and W issued together, response returned on
// a valid/ready port. Optional watchdog: define MY_AXI4_LITE_MST_TIMEOUT_EN.
module my_axi4_lite_mst #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_is_wr,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_timeout,
  axi4_lite_if.mst_port               if_m_axi4_lite
);

  localparam int STRB_W = DATA_BIT_WIDTH / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_AW_W = 3'd1;
  localparam logic [2:0] WR_B    = 3'd2;
  localparam logic [2:0] RD_AR   = 3'd3;
  localparam logic [2:0] RD_R    = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  if (if_m_axi4_lite.ADDR_BIT_WIDTH != ADDR_BIT_WIDTH) begin : g_addr_chk
    $error("my_axi4_lite_mst: ADDR_BIT_WIDTH differs from interface");
  end
  if (if_m_axi4_lite.DATA_BIT_WIDTH != DATA_BIT_WIDTH) begin : g_data_chk
    $error("my_axi4_lite_mst: DATA_BIT_WIDTH differs from interface");
  end
  if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_dw_chk
    $error("my_axi4_lite_mst: DATA_BIT_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("my_axi4_lite_mst: TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]                state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      is_wr_q, is_wr_d;
  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_is_wr_q, rsp_is_wr_d;
  logic [DATA_BIT_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  // Next-state logic: command capture, per-channel handshakes, response hold.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_is_wr_d = rsp_is_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          is_wr_d = i_cmd_is_wr;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          wstrb_d = i_cmd_wstrb;
          if (i_cmd_is_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // AW and W retire independently; leave once both have completed.
        if (awvalid_q && if_m_axi4_lite.awready) awvalid_d = 1'b0;
        if (wvalid_q && if_m_axi4_lite.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (bready_q && if_m_axi4_lite.bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = is_wr_q;
          rsp_rdata_d = '0;
          rsp_resp_d  = if_m_axi4_lite.bresp;
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (arvalid_q && if_m_axi4_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (rready_q && if_m_axi4_lite.rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = is_wr_q;
          rsp_rdata_d = if_m_axi4_lite.rdata;
          rsp_resp_d  = if_m_axi4_lite.rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_is_wr_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_is_wr_q <= rsp_is_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_is_wr = rsp_is_wr_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.rready  = rready_q;

`ifdef MY_AXI4_LITE_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic             busy;

  // Watchdog: restarts on acceptance, counts bus-waiting states, saturates.
  always_comb begin
    busy      = (state_q == WR_AW_W) || (state_q == WR_B) ||
                (state_q == RD_AR)   || (state_q == RD_R);
    wd_cnt_d  = wd_cnt_q;
    if (state_q == IDLE && i_cmd_valid) begin
      wd_cnt_d = '0;
    end else if (busy && wd_cnt_q != CNT_LIMIT) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q | (wd_cnt_d == CNT_LIMIT);
  end

  // Watchdog registers; the flag is sticky until reset.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_my_axi4_lite_mst.sv
// Self-checking bench for my_axi4_lite_mst: configurable 4-register AXI4-Lite
// slave model plus a scoreboard of expected responses.
module tb_my_axi4_lite_mst;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  typedef struct packed {
    logic          is_wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cmd_valid, i_cmd_is_wr, i_rsp_ready;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [SW-1:0] i_cmd_wstrb;
  logic          o_cmd_ready, o_rsp_valid, o_rsp_is_wr, o_timeout;
  logic [DW-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_resp;

  int checks = 0;
  int errors = 0;

  rsp_t          exp_q[$];
  logic [DW-1:0] model_regs [4];

  // slave behaviour knobs
  int         aw_wait, w_wait, ar_wait;
  bit         b_early, ar_never, r_never;
  logic [1:0] resp_code;
  int         aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

  logic          aw_got, w_got;
  int            aw_c, w_c, ar_c;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] sregs [4];

  always #5 clk = ~clk;

  axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi ();

  my_axi4_lite_mst #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk          (clk),
    .i_arst_n       (rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_is_wr    (i_cmd_is_wr),
    .i_cmd_addr     (i_cmd_addr),
    .i_cmd_wdata    (i_cmd_wdata),
    .i_cmd_wstrb    (i_cmd_wstrb),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_is_wr    (o_rsp_is_wr),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_resp     (o_rsp_resp),
    .o_timeout      (o_timeout),
    .if_m_axi4_lite (axi)
  );

  // Register slave with per-channel ready delays and optional early B.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_c <= 0; w_c <= 0; ar_c <= 0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      for (int i = 0; i < 4; i++) sregs[i] <= '0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        axi.awready <= 1'b0; aw_got <= 1'b1; s_awaddr <= axi.awaddr; aw_c <= 0; aw_hs <= aw_hs + 1;
        if (b_early) begin axi.bvalid <= 1'b1; axi.bresp <= resp_code; end
      end else if (axi.awvalid && !aw_got) begin
        if (aw_c >= aw_wait) axi.awready <= 1'b1; else aw_c <= aw_c + 1;
      end
      if (axi.wvalid && axi.wready) begin
        axi.wready <= 1'b0; w_got <= 1'b1; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb; w_c <= 0;
        w_hs <= w_hs + 1;
      end else if (axi.wvalid && !w_got) begin
        if (w_c >= w_wait) axi.wready <= 1'b1; else w_c <= w_c + 1;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < SW; b++)
          if (s_wstrb[b]) sregs[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        if (!b_early) begin axi.bvalid <= 1'b1; axi.bresp <= resp_code; end
      end
      if (axi.bvalid && axi.bready) begin axi.bvalid <= 1'b0; b_hs <= b_hs + 1; end
      if (axi.arvalid && axi.arready) begin
        axi.arready <= 1'b0; ar_c <= 0; ar_hs <= ar_hs + 1;
        axi.rdata <= sregs[axi.araddr[3:2]]; axi.rresp <= resp_code; axi.rvalid <= !r_never;
      end else if (axi.arvalid && !ar_never) begin
        if (ar_c >= ar_wait) axi.arready <= 1'b1; else ar_c <= ar_c + 1;
      end
      if (axi.rvalid && axi.rready) begin axi.rvalid <= 1'b0; r_hs <= r_hs + 1; end
    end
  end

  // Reference model: update shadow registers and queue the expected response.
  function automatic void push_exp(input logic is_wr, input logic [AW-1:0] addr,
                                   input logic [DW-1:0] wd, input logic [SW-1:0] st,
                                   input logic [1:0] rc);
    rsp_t e;
    if (is_wr) begin
      for (int b = 0; b < SW; b++)
        if (st[b]) model_regs[addr[3:2]][8*b +: 8] = wd[8*b +: 8];
      e = {1'b1, {DW{1'b0}}, rc};
    end else begin
      e = {1'b0, model_regs[addr[3:2]], rc};
    end
    exp_q.push_back(e);
  endfunction

  task automatic send_cmd(input logic is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] st, input logic [1:0] rc, output bit ok);
    push_exp(is_wr, addr, wd, st, rc);
    i_cmd_is_wr = is_wr; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_wstrb = st;
    i_cmd_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (o_cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output rsp_t obs);
    ok = 1'b0;
    obs = '0;
    for (int n = 0; n < 200; n++) begin
      if (o_rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      obs = {o_rsp_is_wr, o_rsp_rdata, o_rsp_resp};
      i_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_rsp_ready = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    b_early = 1'b0; ar_never = 1'b0; r_never = 1'b0; resp_code = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got %b want 1", o_cmd_ready);
    end
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi_ctrl got %b want 00000",
                         {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
    end
    checks++;
    if ({o_rsp_valid, o_rsp_is_wr, o_rsp_rdata, o_rsp_resp, o_timeout} !== '0) begin
      errors++; $display("FAIL reset_rsp got v=%b w=%b d=%h r=%b t=%b want all 0",
                         o_rsp_valid, o_rsp_is_wr, o_rsp_rdata, o_rsp_resp, o_timeout);
    end
    checks++;
    if ({axi.awaddr, axi.araddr, axi.wdata, axi.wstrb, axi.awprot, axi.arprot} !== '0) begin
      errors++; $display("FAIL reset_buses got aw=%h ar=%h wd=%h ws=%h want 0",
                         axi.awaddr, axi.araddr, axi.wdata, axi.wstrb);
    end
  endtask

  task automatic test_write_read();
    bit ok, acc; rsp_t obs, e; int aw0, w0, b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    send_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, acc);
    checks++;
    if (!acc || {axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb} !== {2'b11, 4'h4, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL wr_issue got acc=%b awv=%b wv=%b a=%h d=%h s=%h want 1 1 1 4 deadbeef f",
                         acc, axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb);
    end
    wait_rsp(ok, obs); e = exp_q.pop_front();
    checks++;
    if (!ok || obs !== e) begin
      errors++; $display("FAIL wr_rsp got ok=%b %h want %h", ok, obs, e);
    end
    checks++;
    if ((aw_hs - aw0) != 1 || (w_hs - w0) != 1 || (b_hs - b0) != 1) begin
      errors++; $display("FAIL wr_hs_count got aw=%0d w=%0d b=%0d want 1 1 1",
                         aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
    send_cmd(1'b0, 4'h4, '0, '0, 2'b00, acc);
    checks++;
    if (!acc || {axi.arvalid, axi.araddr} !== {1'b1, 4'h4}) begin
      errors++; $display("FAIL rd_issue got acc=%b arv=%b a=%h want 1 1 4", acc, axi.arvalid, axi.araddr);
    end
    wait_rsp(ok, obs); e = exp_q.pop_front();
    checks++;
    if (!ok || obs !== e) begin
      errors++; $display("FAIL rd_rsp got ok=%b %h want %h", ok, obs, e);
    end
  endtask

  task automatic test_wstrb();
    logic [AW+DW+SW:0] tbl [6];
    bit ok, acc; rsp_t obs, e;
    tbl[0] = {1'b1, 4'h8, 32'h11223344, 4'hF};
    tbl[1] = {1'b1, 4'h8, 32'h000000AA, 4'h1};
    tbl[2] = {1'b0, 4'h8, 32'h00000000, 4'h0};
    tbl[3] = {1'b1, 4'hC, 32'hFFFFFFFF, 4'hF};
    tbl[4] = {1'b1, 4'hC, 32'h00000000, 4'h6};
    tbl[5] = {1'b0, 4'hC, 32'h00000000, 4'h0};
    for (int i = 0; i < 6; i++) begin
      send_cmd(tbl[i][AW+DW+SW], tbl[i][DW+SW +: AW], tbl[i][SW +: DW], tbl[i][SW-1:0], 2'b00, acc);
      wait_rsp(ok, obs); e = exp_q.pop_front();
      checks++;
      if (!acc || !ok || obs !== e) begin
        errors++; $display("FAIL wstrb_%0d got acc=%b ok=%b %h want %h", i, acc, ok, obs, e);
      end
    end
  endtask

  task automatic test_split_handshake();
    bit ok, acc, early_b; rsp_t obs, e; int aw_drop, w_drop, b0;
    aw_wait = 0; w_wait = 3; b_early = 1'b1; resp_code = 2'b10;
    b0 = b_hs; aw_drop = -1; w_drop = -1; early_b = 1'b0;
    send_cmd(1'b1, 4'h0, 32'h12345678, 4'hF, 2'b10, acc);
    for (int i = 0; i < 40; i++) begin
      if (aw_drop < 0 && !axi.awvalid) aw_drop = i;
      if (w_drop < 0 && !axi.wvalid) w_drop = i;
      if (!axi.awvalid && axi.wvalid && axi.bvalid && !axi.bready) early_b = 1'b1;
      if (aw_drop >= 0 && w_drop >= 0) break;
      @(negedge clk);
    end
    checks++;
    if (!acc || aw_drop != 2 || w_drop != 5) begin
      errors++; $display("FAIL split_drops got aw=%0d w=%0d want 2 5", aw_drop, w_drop);
    end
    checks++;
    if (!early_b) begin
      errors++; $display("FAIL split_early_b got held_bvalid=0 want 1");
    end
    wait_rsp(ok, obs); e = exp_q.pop_front();
    checks++;
    if (!ok || obs !== e || (b_hs - b0) != 1) begin
      errors++; $display("FAIL split_rsp got ok=%b %h b=%0d want %h b=1", ok, obs, b_hs - b0, e);
    end
    b_early = 1'b0; w_wait = 0; resp_code = 2'b11; ar_wait = 2;
    send_cmd(1'b0, 4'h0, '0, '0, 2'b11, acc);
    wait_rsp(ok, obs); e = exp_q.pop_front();
    checks++;
    if (!acc || !ok || obs !== e) begin
      errors++; $display("FAIL decerr_rsp got ok=%b %h want %h", ok, obs, e);
    end
    resp_code = 2'b00; ar_wait = 0;
  endtask

  task automatic test_backpressure();
    bit ok, acc; rsp_t obs, e; int n;
    send_cmd(1'b0, 4'h4, '0, '0, 2'b00, acc);
    n = 0;
    while (!o_rsp_valid && n < 100) begin @(negedge clk); n++; end
    push_exp(1'b0, 4'h8, '0, '0, 2'b00);
    i_cmd_is_wr = 1'b0; i_cmd_addr = 4'h8; i_cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!o_rsp_valid || o_cmd_ready !== 1'b0 || {o_rsp_is_wr, o_rsp_rdata, o_rsp_resp} !== exp_q[0]) begin
        errors++; $display("FAIL hold_%0d got v=%b rdy=%b %h want 1 0 %h", i, o_rsp_valid, o_cmd_ready,
                           {o_rsp_is_wr, o_rsp_rdata, o_rsp_resp}, exp_q[0]);
      end
      @(negedge clk);
    end
    obs = {o_rsp_is_wr, o_rsp_rdata, o_rsp_resp};
    i_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_rsp_ready = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got %h v=%b rdy=%b want %h 0 1", obs, o_rsp_valid, o_cmd_ready, e);
    end
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    checks++;
    if ({axi.arvalid, axi.araddr} !== {1'b1, 4'h8}) begin
      errors++; $display("FAIL bp_next_cmd got arv=%b a=%h want 1 8", axi.arvalid, axi.araddr);
    end
    wait_rsp(ok, obs); e = exp_q.pop_front();
    checks++;
    if (!acc || !ok || obs !== e) begin
      errors++; $display("FAIL bp_second_rsp got ok=%b %h want %h", ok, obs, e);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, acc; rsp_t obs, e; int n;
    r_never = 1'b1;
    send_cmd(1'b0, 4'h4, '0, '0, 2'b00, acc);
    n = 0;
    while (!axi.rready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!acc || axi.rready !== 1'b1) begin
      errors++; $display("FAIL mid_reach_rd_r got rready=%b want 1", axi.rready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_cmd_ready, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, o_rsp_valid,
         o_rsp_is_wr, o_rsp_rdata, o_rsp_resp, o_timeout, axi.awaddr, axi.araddr, axi.wdata, axi.wstrb}
        !== {1'b1, {(10 + DW + 2*AW + DW + SW){1'b0}}}) begin
      errors++; $display("FAIL mid_async_reset got rdy=%b arv=%b rr=%b v=%b a=%h want 1 0 0 0 0",
                         o_cmd_ready, axi.arvalid, axi.rready, o_rsp_valid, axi.araddr);
    end
    apply_reset();
    send_cmd(1'b0, 4'h4, '0, '0, 2'b00, acc);
    wait_rsp(ok, obs); e = exp_q.pop_front();
    checks++;
    if (!acc || !ok || obs !== e) begin
      errors++; $display("FAIL mid_recover got ok=%b %h want %h", ok, obs, e);
    end
  endtask

  task automatic test_timeout();
    bit acc; logic exp_to;
    ar_never = 1'b1;
    send_cmd(1'b0, 4'h0, '0, '0, 2'b00, acc);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
`ifdef MY_AXI4_LITE_MST_TIMEOUT_EN
      exp_to = (i >= TO);
`else
      exp_to = 1'b0;
`endif
      checks++;
      if (!acc || o_timeout !== exp_to || axi.arvalid !== 1'b1) begin
        errors++; $display("FAIL timeout_cyc%0d got to=%b arv=%b want %b 1", i, o_timeout, axi.arvalid, exp_to);
      end
    end
    apply_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_is_wr = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
    i_rsp_ready = 1'b0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    b_early = 1'b0; ar_never = 1'b0; r_never = 1'b0; resp_code = 2'b00;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_wstrb();
    test_split_handshake();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
